// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte channel into the boot loader.
// master = byte source (valid, data); slave = loader (ready).
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a framed LE byte stream into imem words and
// holds the core in reset until a complete image has landed.
// Ports: clk, rst (sync, active high), start (arm pulse),
//   bus (imem_loader_if.slave byte channel), imem_we/imem_waddr/
//   imem_wdata (registered write port), core_rst, busy, done, err.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  // Where the frame goes after the last payload byte (or N = 0).
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e TAIL_ST   = S_CSUM;
  localparam logic   TAIL_DONE = 1'b0;
`else
  localparam state_e TAIL_ST   = S_DONE;
  localparam logic   TAIL_DONE = 1'b1;
`endif

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         lanes_q, lanes_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        fire;
  logic [15:0] n_full;
  logic        last_word;

  assign busy = (state_q == S_LEN_LO) ||
                (state_q == S_LEN_HI) ||
                (state_q == S_DATA)   ||
                (state_q == S_CSUM);

  assign bus.in_ready = busy;
  assign fire         = bus.in_valid & busy;

  // Full word count as it completes on the LEN_HI byte.
  assign n_full    = {bus.in_data, len_q[7:0]};
  assign last_word = (16'(widx_q) == (len_q - 16'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    lanes_d = lanes_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          widx_d  = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (fire) begin
          len_d   = {8'h00, bus.in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (fire) begin
          len_d = n_full;
          if (n_full > DEPTH16) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = TAIL_ST;
            done_d  = TAIL_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: lanes_d[7:0]   = bus.in_data;
            2'd1: lanes_d[15:8]  = bus.in_data;
            2'd2: lanes_d[23:16] = bus.in_data;
            2'd3: begin
              we_d    = 1'b1;
              waddr_d = widx_q;
              wdata_d = {bus.in_data, lanes_q};
              widx_d  = widx_q + ADDR_W'(1);
              if (last_word) begin
                state_d = TAIL_ST;
                done_d  = TAIL_DONE;
              end
            end
            default: lanes_d = lanes_q;
          endcase
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (fire) begin
          if (bus.in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      lanes_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_rst   = (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. Accepts a framed byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and drives a synchronous word-write port into instruction memory. Holds the single-cycle core in reset until a complete, checked image is in place. Sits between the host-side byte source (UART receiver or testbench) and the instruction memory write port.

## Interface
- `DEPTH`, 128: instruction memory depth in 32-bit words.
- `ADDR_W`, 7: word-address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a new load.
- `in_valid` in 1: byte source has a byte.
- `in_data` in 8: byte value.
- `in_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_waddr` out ADDR_W: word index being written.
- `imem_wdata` out 32: word being written.
- `core_rst` out 1: reset to the core (PC, regfile).
- `busy` out 1: a load is in progress.
- `done` out 1: last load completed successfully; sticky.
- `err` out 1: last load failed; sticky.

## Operation
- Byte transfer: occurs only on a rising edge with `in_valid & in_ready`.
- `in_ready` is combinational from state only. It is high in LEN_LO, LEN_HI, DATA and CSUM, and low otherwise.
- Frame format, in order:
  - word count N, 16-bit little-endian (2 bytes);
  - N×4 payload bytes, little-endian per word;
  - 1 checksum byte, equal to the XOR of all payload bytes (present only with the macro; see Configuration).
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE:
  - `start` → LEN_LO; clears `done`, `err`, word index, byte lane and running XOR.
- LEN_LO:
  - byte → latch N[7:0]; go to LEN_HI.
- LEN_HI:
  - byte → latch N[15:8].
  - N > DEPTH → ERR.
  - N = 0 → CSUM (or DONE without the macro).
  - Otherwise → DATA.
- DATA:
  - Each byte fills lane 0..3 of the word buffer; XOR accumulates.
  - On lane 3: write {b3,b2,b1,b0} at the current word index, then increment the index.
  - After word N-1 → CSUM (or DONE without the macro).
- CSUM:
  - Byte equal to running XOR → DONE.
  - Otherwise → ERR.
- DONE: `done`=1, `core_rst`=0; `start` → LEN_LO.
- ERR: `err`=1, `core_rst`=1; `start` → LEN_LO.
- `start` in LEN_LO/LEN_HI/DATA/CSUM is ignored.
- `busy` = state ∈ {LEN_LO, LEN_HI, DATA, CSUM}.
- `core_rst` = 1 in every state except DONE.
- Words beyond N are not written; stale memory contents remain.

## Timing
- Reset values:
  - state IDLE; `in_ready`=0;
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0;
  - `core_rst`=1, `busy`=0, `done`=0, `err`=0;
  - internal counters and XOR 0.
- `imem_we`, `imem_waddr` and `imem_wdata` are registered. The strobe is high exactly one cycle, the cycle after the lane-3 handshake. Address and data hold until the next write.
- `done`/`err` rise the cycle after the final handshake; `core_rst` falls in the same cycle as `done` rises.
- Back-to-back bytes: one byte per cycle, no bubbles required. `in_valid` low stalls without losing state.
- `rst` mid-load aborts immediately to the reset values. A partially written memory is left as is. No write strobe is issued in the cycle following `rst`.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - CSUM state present; checksum byte required and compared.
  - Mismatch → ERR.
- Not defined:
  - CSUM state and XOR logic removed.
  - Final data word (or LEN_HI with N=0) goes directly to DONE; the frame has no trailing byte.

## Test plan
- Nominal load (macro on): `start`, then bytes 02 00 13 05 10 00 93 05 20 00 B0.
  - Required: two writes, addr 0 = 0x00100513 and addr 1 = 0x00200593.
  - `done`=1, `core_rst`=0 one cycle after the B0 handshake.
- Bad checksum: same stream with last byte B1.
  - Required: both writes still occur, then `err`=1, `done`=0, `core_rst` stays 1.
- Oversize: N = 0x0081 (129 > DEPTH) → ERR after the second byte; no `imem_we` pulse.
- Stall and idle start: `in_valid` toggled 1/0 every cycle during the nominal frame.
  - Required: identical writes and final state.
  - A `start` pulse mid-frame has no effect.
- Reset mid-load: assert `rst` after 6 payload bytes.
  - Required: all outputs at reset values next cycle; word 0 already written.
  - A fresh `start` and full frame then load correctly.
- Macro off: bytes 01 00 EF BE AD DE → one write of 0xDEADBEEF at addr 0, `done`=1 with no checksum byte.
